// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the miner job dispatcher
package miner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK,
    DONE,
    DRAIN
  } state_t;

  localparam int HDR_BITS   = 608;
  localparam int MSG_BITS   = 640;
  localparam int TGT_BITS   = 256;
  localparam int NONCE_BITS = 32;

  localparam logic [0:7][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Nonce travels little-endian inside the block header.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/miner_nonce_msg_builder.sv
// rtl/miner_nonce_msg_builder.sv - packs header prefix and nonce bytes into the core message
module miner_nonce_msg_builder
  import miner_pkg::*;
(
  input  logic [0:HDR_BITS-1]   header,
  input  logic [NONCE_BITS-1:0] nonce,
  output logic [0:MSG_BITS-1]   message
);

  assign message = {header, bswap32(nonce)};

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// rtl/miner_nonce_dispatcher.sv - walks a nonce range through one miner core and reports the outcome
module miner_nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [0:HDR_BITS-1]   job_header,
  input  logic [0:TGT_BITS-1]   job_target,
  input  logic [NONCE_BITS-1:0] nonce_start,
  input  logic [NONCE_BITS-1:0] nonce_end,
  input  logic                  abort,
  output logic                  hash_enable,
  output logic [0:MSG_BITS-1]   message,
  input  logic                  finished,
  input  logic [0:TGT_BITS-1]   hash,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  found,
  output logic                  timeout_err,
  output logic [NONCE_BITS-1:0] found_nonce,
  output logic [31:0]           hashes_done
);

  // WAIT starts one cycle after hash_enable and the error flag lands one cycle after
  // the decision, so expiring at TIMEOUT_CYCLES-2 shows timeout_err at exactly TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t                  state_q, state_d;
  logic [0:HDR_BITS-1]     hdr_q;
  logic [0:TGT_BITS-1]     target_q, hash_q;
  logic [NONCE_BITS-1:0]   nonce_q, end_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    expired, hit, last;

  assign expired      = (cnt_q == EXPIRE_AT);
  assign hit          = (hash_q <= target_q);
  assign last         = (nonce_q == end_q);
  assign job_ready    = (state_q == IDLE);
  assign hash_enable  = (state_q == LAUNCH);
  assign result_valid = (state_q == DONE);

  miner_nonce_msg_builder u_msg (
    .header  (hdr_q),
    .nonce   (nonce_q),
    .message (message)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (job_valid) state_d = LAUNCH;
      LAUNCH: state_d = abort ? IDLE : WAIT;
      WAIT: begin
        // An abort that coincides with the core finishing has nothing left to drain.
        if (abort)         state_d = (finished || expired) ? IDLE : DRAIN;
        else if (finished) state_d = CHECK;
        else if (expired)  state_d = DONE;
      end
      CHECK: begin
        if (abort)            state_d = IDLE;
        else if (hit || last) state_d = DONE;
        else                  state_d = LAUNCH;
      end
      DONE:   if (result_ack) state_d = IDLE;
      DRAIN:  if (finished || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hdr_q       <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      cnt_q       <= '0;
      hashes_done <= '0;
      found       <= 1'b0;
      timeout_err <= 1'b0;
      found_nonce <= '0;
    end else begin
      case (state_q)
        IDLE: if (job_valid) begin
          hdr_q       <= job_header;
          target_q    <= job_target;
          nonce_q     <= nonce_start;
          end_q       <= nonce_end;
          hashes_done <= '0;
        end
        LAUNCH: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (!abort && finished) begin
            hash_q <= hash;
            if (hashes_done != 32'hFFFF_FFFF) hashes_done <= hashes_done + 32'd1;
          end else if (!abort && expired) begin
            timeout_err <= 1'b1;
            found_nonce <= nonce_q;
          end
        end
        CHECK: if (!abort) begin
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= nonce_q;
          end else if (last) begin
            found_nonce <= nonce_q;
          end else begin
            nonce_q <= nonce_q + 32'd1;
          end
        end
        DONE: if (result_ack) begin
          found       <= 1'b0;
          timeout_err <= 1'b0;
        end
        DRAIN: cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// tb/tb_miner_nonce_dispatcher.sv - self-checking bench with a cycle-level core model
module tb_miner_nonce_dispatcher;

  localparam int TO = 1023;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [0:607] job_header = '0;
  logic [0:255] job_target = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic         abort = 1'b0;
  logic         hash_enable;
  logic [0:639] message;
  logic         finished;
  logic [0:255] hash;
  logic         result_valid;
  logic         result_ack = 1'b0;
  logic         found;
  logic         timeout_err;
  logic [31:0]  found_nonce;
  logic [31:0]  hashes_done;

  always #5 clk = ~clk;

  miner_nonce_dispatcher #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
    .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target), .nonce_start(nonce_start),
    .nonce_end(nonce_end), .abort(abort), .hash_enable(hash_enable), .message(message),
    .finished(finished), .hash(hash), .result_valid(result_valid), .result_ack(result_ack),
    .found(found), .timeout_err(timeout_err), .found_nonce(found_nonce), .hashes_done(hashes_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: finished arrives core_lat cycles after hash_enable; hash depends on core_mode.
  int           core_mode = 0;
  logic [31:0]  core_param = '0;
  int           core_lat = 1;
  bit           core_on = 1'b1;
  logic [0:255] cur_tgt = '0;
  logic [31:0]  launched[$];
  logic [31:0]  exp_q[$];
  logic [31:0]  cur_n = '0;
  int           cd = 0;

  function automatic logic [0:255] core_hash(input logic [31:0] n);
    logic [31:0] m;
    m = n * 32'h9E3779B1;
    case (core_mode)
      0:       return {256{1'b1}};
      1:       return (n == core_param) ? cur_tgt : {256{1'b1}};
      default: return {m, {7{n ^ 32'h5A5A5A5A}}};
    endcase
  endfunction

  function automatic logic [31:0] msg_nonce(input logic [0:31] f);
    return {f[24:31], f[16:23], f[8:15], f[0:7]};
  endfunction

  initial begin
    finished = 1'b0;
    hash = '0;
    forever begin
      @(negedge clk);
      finished = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          finished = 1'b1;
          hash = core_hash(cur_n);
        end
      end
      if (hash_enable) begin
        cur_n = msg_nonce(message[608:639]);
        launched.push_back(cur_n);
        if (core_on) cd = core_lat;
      end
    end
  end

  task automatic ref_job(input logic [31:0] s, e, input logic [0:255] t,
                         output logic f, output logic [31:0] fn, cnt);
    logic [31:0] n;
    exp_q.delete();
    n = s; f = 1'b0; cnt = '0;
    for (int g = 0; g < 64; g++) begin
      exp_q.push_back(n);
      cnt++;
      if (core_hash(n) <= t) begin f = 1'b1; break; end
      if (n == e) break;
      n++;
    end
    fn = n;
  endtask

  function automatic int seq_diff();
    int d;
    d = (launched.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++)
      if (launched[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic run_job(input logic [31:0] s, e, input logic [0:255] tgt, input int lat,
                         output logic g_found, g_to, output logic [31:0] g_nonce, g_cnt, g_msgn,
                         output int elapsed);
    logic [0:607] hdr;
    for (int k = 0; k < 19; k++) hdr[k*32 +: 32] = $urandom;
    cur_tgt = tgt;
    core_lat = lat;
    launched.delete();
    @(negedge clk);
    job_valid = 1'b1; job_header = hdr; job_target = tgt; nonce_start = s; nonce_end = e;
    @(negedge clk);
    job_valid = 1'b0;
    chk("launch_latency", hash_enable, 1);
    elapsed = 0;
    while (!result_valid && elapsed < 5000) begin
      @(negedge clk);
      elapsed++;
    end
    chk("result_wait", result_valid, 1);
    g_found = found; g_to = timeout_err; g_nonce = found_nonce; g_cnt = hashes_done;
    g_msgn = message[608:639];
    chk("msg_header", message[0:607] == hdr, 1);
    repeat (3) @(negedge clk);
    chk("result_held", result_valid, 1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ready_after_ack", job_ready, 1);
    chk("cleared_after_ack", {found, timeout_err, result_valid}, 0);
  endtask

  typedef struct {
    logic [31:0]  s;
    logic [31:0]  e;
    logic [0:255] tgt;
    int           mode;
    logic [31:0]  param;
    int           lat;
    logic         exp_found;
    logic [31:0]  exp_nonce;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic         gf, gt, rf;
    logic [31:0]  gn, gc, gm, rn, rc;
    logic [0:255] t3, t;
    logic [31:0]  s, e;
    int           el, lat, bad;

    t3 = {32'h0, {7{32'h11112222}}};
    vecs[0] = '{32'd5, 32'd5, {256{1'b1}}, 0, 32'd0, 10, 1'b1, 32'd5, 32'd1};
    vecs[1] = '{32'hFFFFFFFE, 32'd1, {256{1'b0}}, 0, 32'd0, 3, 1'b0, 32'd1, 32'd4};
    vecs[2] = '{32'd0, 32'd9, t3, 1, 32'd3, 4, 1'b1, 32'd3, 32'd4};
    vecs[3] = '{32'd10, 32'd12, {256{1'b0}}, 0, 32'd0, 1, 1'b0, 32'd12, 32'd3};
    vecs[4] = '{32'hFFFFFFFD, 32'd2, t3, 1, 32'd0, 2, 1'b1, 32'd0, 32'd4};

    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_outputs", {hash_enable, result_valid, found, timeout_err}, 0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_hashes_done", hashes_done, 0);
    chk("rst_message", message == '0, 1);
    n_rst = 1'b1;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ignored", job_ready, 1);

    foreach (vecs[i]) begin
      core_mode = vecs[i].mode;
      core_param = vecs[i].param;
      run_job(vecs[i].s, vecs[i].e, vecs[i].tgt, vecs[i].lat, gf, gt, gn, gc, gm, el);
      chk("vec_found", gf, vecs[i].exp_found);
      chk("vec_nonce", gn, vecs[i].exp_nonce);
      chk("vec_count", gc, vecs[i].exp_cnt);
      chk("vec_timeout", gt, 0);
      chk("vec_elapsed", el, vecs[i].exp_cnt * (vecs[i].lat + 2));
      chk("vec_msg_nonce", gm, {vecs[i].exp_nonce[7:0], vecs[i].exp_nonce[15:8],
                                vecs[i].exp_nonce[23:16], vecs[i].exp_nonce[31:24]});
      exp_q.delete();
      for (int k = 0; k < int'(vecs[i].exp_cnt); k++) exp_q.push_back(vecs[i].s + k);
      chk("vec_sequence", seq_diff(), 0);
    end

    // Random jobs against the range-walk reference model.
    core_mode = 2;
    for (int j = 0; j < 10; j++) begin
      s = (j % 2 == 1) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom;
      e = s + $urandom_range(0, 6);
      t[0:31] = 32'h2AAAAAAA;
      for (int k = 1; k < 8; k++) t[k*32 +: 32] = $urandom;
      lat = $urandom_range(1, 5);
      cur_tgt = t;
      ref_job(s, e, t, rf, rn, rc);
      run_job(s, e, t, lat, gf, gt, gn, gc, gm, el);
      chk("rnd_found", gf, rf);
      chk("rnd_nonce", gn, rn);
      chk("rnd_count", gc, rc);
      chk("rnd_timeout", gt, 0);
      chk("rnd_elapsed", el, rc * (lat + 2));
      chk("rnd_sequence", seq_diff(), 0);
    end

    // Hung core.
    core_mode = 0;
    core_on = 1'b0;
    run_job(32'd7, 32'd7, {256{1'b1}}, 5, gf, gt, gn, gc, gm, el);
    core_on = 1'b1;
    chk("to_flag", gt, 1);
    chk("to_found", gf, 0);
    chk("to_nonce", gn, 7);
    chk("to_count", gc, 0);
    chk("to_elapsed", el, TO);
    chk("to_launches", launched.size(), 1);

    // Abort in WAIT, core finishes 20 cycles later.
    core_lat = 25;
    launched.delete();
    @(negedge clk);
    job_valid = 1'b1; job_target = '0; nonce_start = 32'd0; nonce_end = 32'd5;
    @(negedge clk);
    job_valid = 1'b0;
    chk("abort_launch", hash_enable, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bad = 0;
    for (int k = 6; k <= 25; k++) begin
      if (job_ready || result_valid || hash_enable) bad++;
      @(negedge clk);
    end
    chk("drain_ready_low", bad, 0);
    chk("drain_release", job_ready, 1);
    chk("drain_no_count", hashes_done, 0);
    run_job(32'd9, 32'd9, {256{1'b1}}, 3, gf, gt, gn, gc, gm, el);
    chk("post_drain_found", gf, 1);
    chk("post_drain_nonce", gn, 9);
    chk("post_drain_count", gc, 1);
    chk("post_drain_elapsed", el, 5);

    // Reset in the middle of WAIT.
    core_lat = 30;
    @(negedge clk);
    job_valid = 1'b1; job_target = '0; nonce_start = 32'd0; nonce_end = 32'd3;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_ready", job_ready, 1);
    chk("midrst_outputs", {hash_enable, result_valid, found, timeout_err}, 0);
    chk("midrst_nonce", found_nonce, 0);
    chk("midrst_message", message == '0, 1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (hash_enable || !job_ready) bad++;
    end
    n_rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (hash_enable || !job_ready) bad++;
    end
    chk("midrst_quiet", bad, 0);
    chk("midrst_count", hashes_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
